// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of one single-port RAM with a
// 1-cycle registered read. Registers the winning command onto the RAM port.
module ram_port_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          req_a,
    input  logic          we_a,
    input  logic [AW-1:0] adr_a,
    input  logic [DW-1:0] din_a,
    output logic          gnt_a,
    output logic          rvalid_a,
    input  logic          req_b,
    input  logic          we_b,
    input  logic [AW-1:0] adr_b,
    input  logic [DW-1:0] din_b,
    output logic          gnt_b,
    output logic          rvalid_b,
    output logic [DW-1:0] rdata,
    output logic          ram_ce,
    output logic          ram_we,
    output logic [AW-1:0] ram_adr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } tag_t;

    owner_t        ptr;
    tag_t          tag1, tag2;
    logic          grant;
    owner_t        winner;
    logic          win_we;
    logic [AW-1:0] win_adr;
    logic [DW-1:0] win_din;

    // Grants are held off while in reset so no command can transfer then.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (nrst) begin
            if (req_a && (!req_b || ptr == OWN_A))
                gnt_a = 1'b1;
            else if (req_b)
                gnt_b = 1'b1;
        end
    end

    assign grant   = gnt_a | gnt_b;
    assign winner  = gnt_b ? OWN_B : OWN_A;
    assign win_we  = gnt_b ? we_b  : we_a;
    assign win_adr = gnt_b ? adr_b : adr_a;
    assign win_din = gnt_b ? din_b : din_a;

    always_ff @(posedge clk or negedge nrst) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (!nrst) begin
            ptr     <= OWN_A;
            ram_ce  <= 1'b0;
            ram_we  <= 1'b0;
            ram_adr <= '0;
            ram_din <= '0;
            tag1    <= '0;
            tag2    <= '0;
        end else begin
            ram_ce <= grant;
            if (grant) begin
                ptr     <= (winner == OWN_A) ? OWN_B : OWN_A;
                ram_we  <= win_we;
                ram_adr <= win_adr;
                ram_din <= win_din;
            end
            // Stage1 covers the RAM access cycle, stage2 the cycle dout is valid.
            tag1 <= '{valid: grant && !win_we, owner: winner};
            tag2 <= tag1;
        end
    end

    assign rvalid_a = tag2.valid && (tag2.owner == OWN_A);
    assign rvalid_b = tag2.valid && (tag2.owner == OWN_B);
    assign rdata    = ram_dout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural single-port RAM
// (1-cycle registered read, resets to all-ones).
module tb_ram_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          nrst;
    logic          req_a, we_a, gnt_a, rvalid_a;
    logic [AW-1:0] adr_a;
    logic [DW-1:0] din_a;
    logic          req_b, we_b, gnt_b, rvalid_b;
    logic [AW-1:0] adr_b;
    logic [DW-1:0] din_b;
    logic [DW-1:0] rdata;
    logic          ram_ce, ram_we;
    logic [AW-1:0] ram_adr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic [DW-1:0] mem [2**AW];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .nrst(nrst),
        .req_a(req_a), .we_a(we_a), .adr_a(adr_a), .din_a(din_a),
        .gnt_a(gnt_a), .rvalid_a(rvalid_a),
        .req_b(req_b), .we_b(we_b), .adr_b(adr_b), .din_b(din_b),
        .gnt_b(gnt_b), .rvalid_b(rvalid_b),
        .rdata(rdata),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_adr(ram_adr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= '1;
            ram_dout <= '1;
        end else if (ram_ce) begin
            if (ram_we) mem[ram_adr] <= ram_din;
            else        ram_dout     <= mem[ram_adr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Grant exclusivity and grant-implies-request, every cycle out of reset.
    always @(negedge clk) begin
        if (nrst === 1'b1) begin
            check("gnt_excl", {31'b0, gnt_a & gnt_b}, 0);
            check("gnt_req", {31'b0, (gnt_a & ~req_a) | (gnt_b & ~req_b)}, 0);
        end
    end

    task automatic drive(input logic ra, wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                         input logic rb, wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
        req_a = ra; we_a = wa; adr_a = aa; din_a = da;
        req_b = rb; we_b = wb; adr_b = ab; din_b = db;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nrst = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        check("rst_gnt_a", gnt_a, 0);
        check("rst_gnt_b", gnt_b, 0);
        check("rst_rvalid_a", rvalid_a, 0);
        check("rst_rvalid_b", rvalid_b, 0);
        check("rst_ram_ce", ram_ce, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_adr", ram_adr, 0);
        check("rst_ram_din", ram_din, 0);
        tick();
        nrst = 1'b1;

        // A reads adr 3 from reset contents
        drive(1, 0, 3, 0, 0, 0, 0, 0);
        @(negedge clk); check("t1_gnt_a", gnt_a, 1); check("t1_gnt_b", gnt_b, 0);
        tick(); idle();
        @(negedge clk); check("t1_ce", ram_ce, 1); check("t1_adr", ram_adr, 3);
        check("t1_we", ram_we, 0); check("t1_rv_early", rvalid_a, 0);
        tick();
        @(negedge clk); check("t1_rvalid_a", rvalid_a, 1); check("t1_rdata", rdata, 8'hFF);
        check("t1_rvalid_b", rvalid_b, 0);
        tick();
        @(negedge clk); check("t1_rv_off", rvalid_a, 0); check("t1_ce_off", ram_ce, 0);
        tick();

        // A writes 5A to adr 2, then reads it back on the next grant
        drive(1, 1, 2, 8'h5A, 0, 0, 0, 0);
        @(negedge clk); check("t2_gnt_w", gnt_a, 1);
        tick(); drive(1, 0, 2, 0, 0, 0, 0, 0);
        @(negedge clk); check("t2_gnt_r", gnt_a, 1); check("t2_we", ram_we, 1);
        check("t2_din", ram_din, 8'h5A); check("t2_no_rv", rvalid_a, 0);
        tick(); idle();
        @(negedge clk); check("t2_rv_early", rvalid_a, 0);
        tick();
        @(negedge clk); check("t2_rvalid_a", rvalid_a, 1); check("t2_rdata", rdata, 8'h5A);
        check("t2_rvalid_b", rvalid_b, 0);
        tick();

        // Seed adr 1 (A) and adr 4 (B); B's lone grant leaves the pointer on A
        drive(1, 1, 1, 8'h11, 0, 0, 0, 0);
        @(negedge clk); check("t3_seed_a", gnt_a, 1);
        tick(); drive(0, 0, 0, 0, 1, 1, 4, 8'h44);
        @(negedge clk); check("t3_seed_b", gnt_b, 1);
        tick();

        // Both read for 6 cycles: strict alternation A,B,A,B,A,B
        for (int j = 0; j < 8; j++) begin
            if (j < 6) drive(1, 0, 1, 0, 1, 0, 4, 0);
            else       idle();
            @(negedge clk);
            if (j < 6) begin
                check($sformatf("t3_gnt_a%0d", j), gnt_a, (j % 2 == 0) ? 1 : 0);
                check($sformatf("t3_gnt_b%0d", j), gnt_b, (j % 2 == 1) ? 1 : 0);
            end
            if (j >= 2) begin
                check($sformatf("t3_rv_a%0d", j), rvalid_a, (j % 2 == 0) ? 1 : 0);
                check($sformatf("t3_rv_b%0d", j), rvalid_b, (j % 2 == 1) ? 1 : 0);
                check($sformatf("t3_rd%0d", j), rdata, (j % 2 == 0) ? 8'h11 : 8'h44);
            end
            tick();
        end

        // B alone 3 cycles, then a tie: A wins, B granted right after
        for (int j = 0; j < 3; j++) begin
            drive(0, 0, 0, 0, 1, 1, 9, 8'h0B);
            @(negedge clk);
            check($sformatf("t4_b_only%0d", j), gnt_b, 1);
            tick();
        end
        drive(1, 0, 4, 0, 1, 1, 9, 8'h0B);
        @(negedge clk); check("t4_tie_a", gnt_a, 1); check("t4_tie_b", gnt_b, 0);
        tick(); drive(0, 0, 0, 0, 1, 1, 9, 8'h0B);
        @(negedge clk); check("t4_loser_b", gnt_b, 1);
        tick(); idle();
        @(negedge clk); check("t4_rvalid_a", rvalid_a, 1); check("t4_rdata", rdata, 8'h44);
        tick();

        // Read granted, reset the next cycle: the read is dropped
        drive(1, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk); check("t5_gnt", gnt_a, 1);
        tick(); idle(); nrst = 1'b0;
        @(negedge clk); check("t5_ce_rst", ram_ce, 0); check("t5_rv_rst", rvalid_a, 0);
        tick(); nrst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check($sformatf("t5_rv_a%0d", j), rvalid_a, 0);
            check($sformatf("t5_rv_b%0d", j), rvalid_b, 0);
            tick();
        end

        // A write and B read contend; the loser holds and wins next cycle
        drive(1, 1, 5, 8'h77, 1, 0, 5, 0);
        @(negedge clk); check("t6_gnt_a", gnt_a, 1); check("t6_gnt_b0", gnt_b, 0);
        tick(); drive(0, 0, 0, 0, 1, 0, 5, 0);
        @(negedge clk); check("t6_gnt_b", gnt_b, 1); check("t6_gnt_a1", gnt_a, 0);
        tick(); idle();
        @(negedge clk); check("t6_rv_early", rvalid_b, 0);
        tick();
        @(negedge clk); check("t6_rvalid_b", rvalid_b, 1); check("t6_rvalid_a", rvalid_a, 0);
        check("t6_rdata", rdata, 8'h77);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
